// File: rtl/gs_sequencer_pkg.sv
// Shared definitions for the grayscale stage: controller state encoding and
// the default frame geometry also used by the grayscaler and the memories.
package gs_sequencer_pkg;

  localparam int GS_IMG_W = 2;
  localparam int GS_IMG_H = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } gs_state_e;

  // Number of grayscale results (one per pixel) in a frame.
  function automatic int gs_npix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/gs_sequencer_wr_stage.sv
// gs_wr_stage: result capture register for the grayscale sequencer.
// A capture strobe registers the result byte and its destination address;
// the write strobe follows one cycle later.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   cap_i        capture the current result this cycle
//   pix_i        pixel index of the captured result
//   data_i       captured result byte
//   dst_we_o     destination write strobe (one cycle after capture)
//   dst_addr_o   DST_BASE + pixel index, truncated to ADDR_W
//   dst_data_o   registered result byte
module gs_wr_stage
  import gs_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DST_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [ADDR_W-1:0] pix_i,
  input  logic [7:0]        data_i,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [7:0]        dst_data_o
);

  localparam logic [ADDR_W-1:0] DST_BASE_A = ADDR_W'(DST_BASE);

  logic              we_q,   we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  always_comb begin
    we_d   = cap_i;
    addr_d = addr_q;
    data_d = data_q;
    if (cap_i) begin
      addr_d = DST_BASE_A + pix_i;
      data_d = data_i;
    end
  end

  // capture -> write stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= DST_BASE_A;
      data_q <= 8'h00;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign dst_we_o   = we_q;
  assign dst_addr_o = addr_q;
  assign dst_data_o = data_q;

endmodule

// File: rtl/gs_sequencer.sv
// gs_sequencer: controller for the grayscale stage. On start it streams
// 3*W*H RGB bytes from source memory into the grayscaler (honouring its pause
// request), writes each of the W*H results to destination memory and then
// reports completion or a drain timeout.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   start, abort       frame start (IDLE only) and synchronous abort
//   busy, done, err    status: active, completion pulse, sticky timeout
//   src_rd_en/addr     source memory read port
//   gs_enable/pause    grayscaler enable and its pause request
//   gs_valid/data      grayscaler result strobe and byte
//   gs_done            grayscaler frame status (informational, unused)
//   dst_we/addr/data   destination memory write port
module gs_sequencer
  import gs_sequencer_pkg::*;
#(
  parameter int IMG_W    = GS_IMG_W,
  parameter int IMG_H    = GS_IMG_H,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  output logic              gs_enable,
  input  logic              gs_pause,
  input  logic              gs_valid,
  input  logic [7:0]        gs_data,
  input  logic              gs_done,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data
);

  localparam int                NPIX       = gs_npix(IMG_W, IMG_H);
  localparam int                IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE  = ADDR_W'(3 * NPIX - 1);
  localparam logic [ADDR_W-1:0] NPIX_A     = ADDR_W'(NPIX);
  localparam logic [ADDR_W-1:0] SRC_BASE_A = ADDR_W'(SRC_BASE);
  localparam logic [IDLE_W-1:0] TIMEOUT_C  = IDLE_W'(TIMEOUT);

  gs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic              err_q, err_d;
  logic              active, rd_fire, capture;

  // Completion is signalled by our own pixel count, never by the grayscaler.
  logic gs_done_unused;
  assign gs_done_unused = gs_done;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = err_q;
    idle_inc   = idle_cnt_q + IDLE_W'(1);

    active  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    rd_fire = (state_q == ST_FETCH) && !gs_pause;
    // Results beyond the frame size, or arriving with an abort, are dropped.
    capture = active && gs_valid && (pix_cnt_q != NPIX_A) && !abort;

    if (rd_fire) byte_cnt_d = byte_cnt_q + ADDR_W'(1);
    if (capture) pix_cnt_d = pix_cnt_q + ADDR_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          idle_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_FETCH: begin
        if (rd_fire && (byte_cnt_q == LAST_BYTE)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // pix_cnt reaches the frame size the same cycle the last write issues.
        if (pix_cnt_q == NPIX_A) begin
          state_d = ST_DONE;
        end else if (gs_valid) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc;
          if (idle_inc == TIMEOUT_C) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including an accepted start or a timeout.
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = err_q;
      if (state_q == ST_IDLE) begin
        byte_cnt_d = byte_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        idle_cnt_d = idle_cnt_q;
      end
    end
  end

  // control register stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      pix_cnt_q  <= '0;
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy      = active;
  assign gs_enable = active;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign src_rd_en = rd_fire;
  assign src_addr  = SRC_BASE_A + byte_cnt_q;

  gs_wr_stage #(
    .ADDR_W  (ADDR_W),
    .DST_BASE(DST_BASE)
  ) u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_i     (capture),
    .pix_i     (pix_cnt_q),
    .data_i    (gs_data),
    .dst_we_o  (dst_we),
    .dst_addr_o(dst_addr),
    .dst_data_o(dst_data)
  );

endmodule

// File: tb/tb_gs_sequencer.sv
// Self-checking bench for gs_sequencer. A behavioural grayscaler/memory model
// answers the source reads with random bytes, returns one result per RGB
// triple a few cycles later, and records every read, write and done pulse.
// Expected reads, writes and timings come from the frame rules directly.
module tb_gs_sequencer;

  localparam int AW = 16;
  localparam int SB = 'h40;
  localparam int DB = 'h80;
  localparam int TO = 8;
  localparam int NP = 4;
  localparam int NB = 3 * NP;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, busy, done, err;
  logic          src_rd_en, gs_enable, gs_pause, gs_valid, gs_done, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    gs_data, dst_data;

  always #5 clk = ~clk;

  gs_sequencer #(
    .IMG_W(2), .IMG_H(2), .ADDR_W(AW), .SRC_BASE(SB), .DST_BASE(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .gs_enable(gs_enable),
    .gs_pause(gs_pause), .gs_valid(gs_valid), .gs_data(gs_data), .gs_done(gs_done),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
  } ev_t;

  ev_t        sched_q[$];
  int         rd_q[$];
  int         wa_q[$];
  int         wd_q[$];
  logic [7:0] srcmem [NB];
  logic [7:0] trip [3];
  int         passes = 0, fails = 0, total = 0, cyc = 0;
  int         nbytes, first_rd_cyc, last_rd_cyc, done_cnt, viol, err_cyc, pause_left;
  bit         err_seen, err_gsen, pause_mode, no_valid, extra, start_req, abort_req;

  function automatic logic [7:0] gray(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    int s;
    s = int'(r) + 2 * int'(g) + int'(b);
    return 8'(s >> 2);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    sched_q.delete(); rd_q.delete(); wa_q.delete(); wd_q.delete();
    nbytes = 0; first_rd_cyc = 0; last_rd_cyc = 0; done_cnt = 0; viol = 0;
    err_seen = 0; err_cyc = 0; err_gsen = 0; pause_left = 0;
    for (int i = 0; i < NB; i++) srcmem[i] = 8'($urandom);
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe.
  task automatic tick();
    int  idx;
    ev_t e;
    @(negedge clk);
    start = start_req; abort = abort_req;
    start_req = 0; abort_req = 0;
    gs_pause = (pause_left > 0);
    if (pause_left > 0) pause_left--;
    gs_valid = 1'b0; gs_data = 8'h00;
    if (sched_q.size() > 0 && sched_q[0].due <= cyc) begin
      gs_valid = 1'b1;
      gs_data  = sched_q[0].data;
      void'(sched_q.pop_front());
    end
    #1;
    if (gs_pause && src_rd_en) viol++;
    if (gs_pause && gs_enable && nbytes < NB && src_addr != AW'(SB + nbytes)) viol++;
    if (src_rd_en) begin
      idx = int'(src_addr) - SB;
      rd_q.push_back(idx);
      if (nbytes == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      trip[nbytes % 3] = (idx >= 0 && idx < NB) ? srcmem[idx] : 8'h00;
      nbytes++;
      if (nbytes % 3 == 0) begin
        if (!no_valid) begin
          e.due = cyc + 3; e.data = gray(trip[0], trip[1], trip[2]);
          sched_q.push_back(e);
        end
        if (extra && nbytes == NB) begin
          e.due = cyc + 4; e.data = 8'h5A;
          sched_q.push_back(e);
        end
        if (pause_mode) pause_left = 2;
      end
    end
    if (dst_we) begin
      wa_q.push_back(int'(dst_addr) - DB);
      wd_q.push_back(int'(dst_data));
    end
    if (done) done_cnt++;
    if (err && !err_seen) begin
      err_seen = 1; err_cyc = cyc; err_gsen = gs_enable;
    end
    cyc++;
  endtask

  // mode 0: wait for a done pulse; mode 1: wait for err to rise.
  task automatic wait_for(input int mode, input int budget, input string tag);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      hit = (mode == 0) ? (done_cnt > 0) : err_seen;
    end
    chk({tag, "_reached"}, int'(hit), 1);
  endtask

  task automatic check_frame(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_rd_count"}, rd_q.size(), NB);
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) bad++;
    chk({tag, "_rd_order"}, bad, 0);
    chk({tag, "_wr_count"}, wa_q.size(), NP);
    for (int i = 0; i < wa_q.size() && i < NP; i++) begin
      chk({tag, "_wr_addr"}, wa_q[i], i);
      chk({tag, "_wr_data"}, wd_q[i],
          int'(gray(srcmem[3*i], srcmem[3*i+1], srcmem[3*i+2])));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_src_rd_en"}, int'(src_rd_en), 0);
    chk({tag, "_src_addr"}, int'(src_addr), SB);
    chk({tag, "_gs_enable"}, int'(gs_enable), 0);
    chk({tag, "_dst_we"}, int'(dst_we), 0);
    chk({tag, "_dst_addr"}, int'(dst_addr), DB);
    chk({tag, "_dst_data"}, int'(dst_data), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    gs_pause = 1'b0; gs_valid = 1'b0; gs_data = 8'h00; gs_done = 1'b0;
    pause_mode = 0; no_valid = 0; extra = 0; start_req = 0; abort_req = 0;
    new_frame();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Plain frame: back-to-back reads, result three cycles after each triple.
    new_frame();
    start_req = 1; tick();
    wait_for(0, 60, "t1_done");
    tick(); tick();
    check_frame("t1");
    chk("t1_rd_span", last_rd_cyc - first_rd_cyc, NB - 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", int'(err), 0);
    chk("t1_busy_after", int'(busy), 0);

    // Pause for two cycles after every third byte.
    new_frame();
    pause_mode = 1;
    start_req = 1; tick();
    wait_for(0, 80, "t2_done");
    tick(); tick();
    check_frame("t2");
    chk("t2_pause_rule", viol, 0);
    chk("t2_rd_span", last_rd_cyc - first_rd_cyc, NB - 1 + 2 * 3);
    chk("t2_done_cnt", done_cnt, 1);
    pause_mode = 0;

    // No results at all: drain times out after TO idle cycles.
    new_frame();
    no_valid = 1;
    start_req = 1; tick();
    wait_for(1, 60, "t3_err");
    chk("t3_timeout_latency", err_cyc - last_rd_cyc, TO + 1);
    chk("t3_err_gs_enable", int'(err_gsen), 0);
    chk("t3_rd_count", rd_q.size(), NB);
    tick();
    chk("t3_idle_busy", int'(busy), 0);
    chk("t3_err_sticky", int'(err), 1);
    tick();
    chk("t3_no_done", done_cnt, 0);
    no_valid = 0;
    new_frame();
    start_req = 1; tick();
    tick();
    chk("t3_err_cleared", int'(err), 0);
    wait_for(0, 60, "t3_rerun_done");
    tick();
    chk("t3_rerun_done_cnt", done_cnt, 1);

    // Abort while byte 5 is being fetched, then restart from the base.
    new_frame();
    start_req = 1; tick();
    repeat (5) tick();
    abort_req = 1; tick();
    chk("t4_abort_addr", (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1, 5);
    tick();
    chk("t4_busy", int'(busy), 0);
    chk("t4_gs_enable", int'(gs_enable), 0);
    chk("t4_src_rd_en", int'(src_rd_en), 0);
    repeat (8) tick();
    chk("t4_no_done", done_cnt, 0);
    chk("t4_rd_count", rd_q.size(), 6);
    new_frame();
    start_req = 1; tick();
    tick();
    chk("t4_restart_addr", (rd_q.size() > 0) ? rd_q[0] : -1, 0);
    wait_for(0, 60, "t4_done");
    tick(); tick();
    check_frame("t4");
    chk("t4_done_cnt", done_cnt, 1);

    // A fifth result for a four-pixel frame must be dropped.
    new_frame();
    extra = 1;
    start_req = 1; tick();
    wait_for(0, 60, "t5_done");
    repeat (4) tick();
    check_frame("t5");
    chk("t5_done_cnt", done_cnt, 1);
    extra = 0;

    // Start while busy is ignored; reset in the middle of drain.
    new_frame();
    no_valid = 1;
    start_req = 1; tick();
    repeat (3) tick();
    start_req = 1; tick();
    n = 0;
    while (nbytes < NB && n < 30) begin
      tick();
      n++;
    end
    chk("t6_fetch_finished", int'(nbytes == NB), 1);
    repeat (2) tick();
    chk("t6_in_drain_busy", int'(busy), 1);
    chk("t6_in_drain_rd_en", int'(src_rd_en), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    n = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) n++;
    chk("t6_rd_order", n, 0);
    chk("t6_rd_count", rd_q.size(), NB);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    no_valid = 0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
